multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, 16, consecutive not-ready cycles in a memory wait state before fault (range 1..255).
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instruction  input  32  instruction word; sampled in FETCH when mem_ready=1.
REQ-005 mem_ready  input  1  memory completion for the current mem_req.
REQ-006 branch_taken  input  1  datapath comparator result; qualified only in EXECUTE for branch.
REQ-007 mem_req  output  1  memory access request (fetch or data).
REQ-008 MemRW  output  1  1=store write, 0=read.
REQ-009 IRWEn  output  1  instruction-register load strobe.
REQ-010 ImmSel  output  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J, 111 none.
REQ-011 Bsel  output  1  ALU B operand: 1=immediate, 0=rs2.
REQ-012 ALUSel  output  4  ALU operation code.
REQ-013 branch_type  output  3  funct3 of latched branch, else 000.
REQ-014 RegWEn  output  1  register-file write enable.
REQ-015 WBSel  output  2  writeback source: 00 ALU, 01 memory, 10 PC+4.
REQ-016 PCWEn  output  1  PC update strobe.
REQ-017 pc_sel  output  2  next PC: 00 PC+4, 01 branch target, 10 JAL target.
REQ-018 fault  output  1  sticky fault indication.
REQ-019 state  output  3  current FSM state encoding.

Function
REQ-020 FSM states/encodings SHALL be FETCH 0, DECODE 1, EXECUTE 2, MEMORY 3, WRITEBACK 4, FAULT 5; outputs are Moore-decoded from state plus latched fields.
REQ-021 FETCH: mem_req=1, MemRW=0; on mem_ready=1 IRWEn=1 same cycle, latch opcode, funct3, funct7[5], go DECODE; else stay.
REQ-022 DECODE: legal opcodes R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, JAL 1101111 go EXECUTE; any other opcode goes FAULT.
REQ-023 EXECUTE: BRANCH -> PCWEn=1, pc_sel=01 if branch_taken else 00, go FETCH; LOAD/STORE -> MEMORY; R/I/LUI/JAL -> WRITEBACK.
REQ-024 MEMORY: mem_req=1, MemRW=1 for STORE else 0; on mem_ready STORE asserts PCWEn=1 pc_sel=00 and goes FETCH, LOAD goes WRITEBACK.
REQ-025 WRITEBACK: RegWEn=1, PCWEn=1, one cycle, go FETCH; WBSel 01 LOAD, 10 JAL, else 00; pc_sel 10 for JAL else 00.
REQ-026 PCWEn SHALL pulse exactly once per retired instruction; RegWEn only in WRITEBACK; mem_req only in FETCH/MEMORY.
REQ-027 ALUSel SHALL be {q, funct3} for R and I, q=funct7[5] when funct3 is 000 (R only) or 101 (R and I), else 0; LOAD/STORE/LUI/JAL 0000; BRANCH 1000.
REQ-028 Bsel=1 for I, LOAD, STORE, LUI, JAL; 0 for R, BRANCH. ImmSel per format; R gives 111.
REQ-029 ImmSel, Bsel, ALUSel, branch_type SHALL be driven from latched fields in DECODE through WRITEBACK; all control outputs 0 (ImmSel 111) in FETCH and FAULT except per REQ-021.
REQ-030 FAULT: fault=1, all strobes 0, no exit except reset.

Reset
REQ-031 reset asserted at any time SHALL force state FETCH, latched fields 0, timeout counter 0, fault 0 immediately (asynchronously).
REQ-032 While reset is high all outputs SHALL be 0 (ImmSel 111); first mem_req is in the first cycle after deassertion.
REQ-033 Reset mid-MEMORY SHALL abandon the access with no PCWEn/RegWEn.

Configuration
REQ-034 Macro CTRL_TIMEOUT_EN defined: counter (width $clog2(MEM_TIMEOUT+1)) clears on entering FETCH/MEMORY and on mem_ready, increments each wait cycle with mem_ready=0; after MEM_TIMEOUT consecutive such cycles next state is FAULT.
REQ-035 CTRL_TIMEOUT_EN undefined: no counter; FETCH/MEMORY wait indefinitely; FAULT reachable only via illegal opcode.

Verification
REQ-036 ADD 0x002081B3, ready on 2nd FETCH cycle -> FETCH,FETCH,DECODE,EXECUTE(ALUSel 0000,Bsel 0),WRITEBACK(RegWEn 1,WBSel 00,PCWEn 1),FETCH.
REQ-037 SUB 0x402081B3 -> ALUSel 1000; SRAI 0x4030D193 -> ALUSel 1101, Bsel 1, ImmSel 000.
REQ-038 LW 0x0080A283, mem_ready low 3 MEMORY cycles -> mem_req 1, MemRW 0 for 4 cycles, then WRITEBACK WBSel 01.
REQ-039 SW 0x0050A423 -> MEMORY MemRW 1, PCWEn 1 on ready, RegWEn never 1; BEQ 0x00208463 with branch_taken 1 -> EXECUTE PCWEn 1, pc_sel 01, branch_type 000.
REQ-040 FENCE 0x0000000F -> DECODE then FAULT, fault 1 held until reset; reset mid-MEMORY -> state 0, fault 0.
REQ-041 MEM_TIMEOUT=4, CTRL_TIMEOUT_EN, mem_ready held 0 -> FAULT after 4 FETCH cycles; without macro state stays FETCH for 100 cycles.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for an RV32 subset (R, I, LOAD, STORE, BRANCH, LUI, JAL).
// Define CTRL_TIMEOUT_EN to fault after MEM_TIMEOUT consecutive memory wait cycles.

// state     | meaning
// FETCH     | request instruction, load IR on mem_ready
// DECODE    | check opcode legality
// EXECUTE   | ALU op; branches resolve and retire here
// MEMORY    | data access for LOAD/STORE; STORE retires here
// WRITEBACK | register write and PC update
// FAULT     | sticky error, left only by reset
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        MemRW,
  output logic        IRWEn,
  output logic [2:0]  ImmSel,
  output logic        Bsel,
  output logic [3:0]  ALUSel,
  output logic [2:0]  branch_type,
  output logic        RegWEn,
  output logic [1:0]  WBSel,
  output logic        PCWEn,
  output logic [1:0]  pc_sel,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be within 1..255");
  end

  state_t     cur, nxt;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       timed_out;
  logic       unused_instr;

  assign unused_instr = ^{instruction[31], instruction[29:15], instruction[11:7]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode    <= '0;
      funct3    <= '0;
      funct7_b5 <= 1'b0;
    end else if (cur == FETCH && mem_ready) begin
      opcode    <= instruction[6:0];
      funct3    <= instruction[14:12];
      funct7_b5 <= instruction[30];
    end
  end

  logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_jal, legal;
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_ld  = (opcode == OP_LOAD);
  assign is_st  = (opcode == OP_STORE);
  assign is_br  = (opcode == OP_BRANCH);
  assign is_lui = (opcode == OP_LUI);
  assign is_jal = (opcode == OP_JAL);
  assign legal  = is_r | is_i | is_ld | is_st | is_br | is_lui | is_jal;

`ifdef CTRL_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_TC = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;
  logic          waiting;

  assign waiting   = (cur == FETCH || cur == MEMORY) && !mem_ready;
  assign timed_out = waiting && (wait_cnt == WAIT_TC);

  // Any state change or completed access restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= '0;
    else if (waiting && nxt == cur) wait_cnt <= wait_cnt + 1'b1;
    else wait_cnt <= '0;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= FETCH;
    else cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH: begin
        if (mem_ready) nxt = DECODE;
        else if (timed_out) nxt = FAULT;
      end
      DECODE:  nxt = legal ? EXECUTE : FAULT;
      EXECUTE: begin
        if (is_br) nxt = FETCH;
        else if (is_ld || is_st) nxt = MEMORY;
        else nxt = WRITEBACK;
      end
      MEMORY: begin
        if (mem_ready) nxt = is_st ? FETCH : WRITEBACK;
        else if (timed_out) nxt = FAULT;
      end
      WRITEBACK: nxt = FETCH;
      FAULT:     nxt = FAULT;
      default:   nxt = FAULT;
    endcase
  end

  logic [2:0] imm_fmt;
  logic [3:0] alu_op;
  logic       alu_q;

  always_comb begin
    imm_fmt = 3'b111;
    if (is_i || is_ld) imm_fmt = 3'b000;
    else if (is_st)    imm_fmt = 3'b001;
    else if (is_br)    imm_fmt = 3'b010;
    else if (is_lui)   imm_fmt = 3'b011;
    else if (is_jal)   imm_fmt = 3'b100;
  end

  // funct7[5] selects SUB/SRA; only shifts qualify it for immediates.
  always_comb begin
    alu_q  = 1'b0;
    alu_op = 4'b0000;
    if (is_r) begin
      alu_q  = funct7_b5 && (funct3 == 3'b000 || funct3 == 3'b101);
      alu_op = {alu_q, funct3};
    end else if (is_i) begin
      alu_q  = funct7_b5 && (funct3 == 3'b101);
      alu_op = {alu_q, funct3};
    end else if (is_br) begin
      alu_op = 4'b1000;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    MemRW       = 1'b0;
    IRWEn       = 1'b0;
    ImmSel      = 3'b111;
    Bsel        = 1'b0;
    ALUSel      = 4'b0000;
    branch_type = 3'b000;
    RegWEn      = 1'b0;
    WBSel       = 2'b00;
    PCWEn       = 1'b0;
    pc_sel      = 2'b00;
    fault       = 1'b0;
    if (!reset) begin
      if (cur inside {DECODE, EXECUTE, MEMORY, WRITEBACK}) begin
        ImmSel      = imm_fmt;
        Bsel        = is_i | is_ld | is_st | is_lui | is_jal;
        ALUSel      = alu_op;
        branch_type = is_br ? funct3 : 3'b000;
      end
      case (cur)
        FETCH: begin
          mem_req = 1'b1;
          IRWEn   = mem_ready;
        end
        EXECUTE: begin
          if (is_br) begin
            PCWEn  = 1'b1;
            pc_sel = branch_taken ? 2'b01 : 2'b00;
          end
        end
        MEMORY: begin
          mem_req = 1'b1;
          MemRW   = is_st;
          PCWEn   = is_st && mem_ready;
        end
        WRITEBACK: begin
          RegWEn = 1'b1;
          PCWEn  = 1'b1;
          WBSel  = is_ld ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
          pc_sel = is_jal ? 2'b10 : 2'b00;
        end
        FAULT:   fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction walk plus random instruction stream.
// Timeout branch follows CTRL_TIMEOUT_EN.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req, MemRW, IRWEn, Bsel, RegWEn, PCWEn, fault;
  logic [2:0]  ImmSel, branch_type, state;
  logic [3:0]  ALUSel;
  logic [1:0]  WBSel, pc_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .MemRW(MemRW), .IRWEn(IRWEn),
    .ImmSel(ImmSel), .Bsel(Bsel), .ALUSel(ALUSel), .branch_type(branch_type),
    .RegWEn(RegWEn), .WBSel(WBSel), .PCWEn(PCWEn), .pc_sel(pc_sel),
    .fault(fault), .state(state)
  );

  typedef logic [23:0] vec_t;
  typedef enum {C_R, C_I, C_LD, C_ST, C_BR, C_LUI, C_JAL, C_BAD} cls_t;

  localparam logic [10:0] FLD_NONE = {3'd7, 1'b0, 4'd0, 3'd0};

  function automatic vec_t mk(input logic [2:0] st, input logic mrq, input logic mrw,
                              input logic irw, input logic [10:0] fld, input logic rw,
                              input logic [1:0] wb, input logic pw, input logic [1:0] ps,
                              input logic fl);
    return {st, mrq, mrw, irw, fld, rw, wb, pw, ps, fl};
  endfunction

  function automatic vec_t dut_vec();
    return {state, mem_req, MemRW, IRWEn, ImmSel, Bsel, ALUSel, branch_type,
            RegWEn, WBSel, PCWEn, pc_sel, fault};
  endfunction

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'h33:   return C_R;
      7'h13:   return C_I;
      7'h03:   return C_LD;
      7'h23:   return C_ST;
      7'h63:   return C_BR;
      7'h37:   return C_LUI;
      7'h6F:   return C_JAL;
      default: return C_BAD;
    endcase
  endfunction

  // Decoded fields {ImmSel, Bsel, ALUSel, branch_type} expected for an instruction.
  function automatic logic [10:0] fields(input logic [31:0] ins);
    cls_t       c;
    logic [2:0] f3, imm, bt;
    logic       b5, bs;
    int         alu;
    c   = classify(ins[6:0]);
    f3  = ins[14:12];
    b5  = ins[30];
    imm = 3'd7;
    bs  = 1'b0;
    alu = 0;
    bt  = 3'd0;
    case (c)
      C_R:   begin alu = int'(f3) + ((b5 && (f3 == 3'd0 || f3 == 3'd5)) ? 8 : 0); end
      C_I:   begin imm = 3'd0; bs = 1'b1; alu = int'(f3) + ((b5 && f3 == 3'd5) ? 8 : 0); end
      C_LD:  begin imm = 3'd0; bs = 1'b1; end
      C_ST:  begin imm = 3'd1; bs = 1'b1; end
      C_BR:  begin imm = 3'd2; alu = 8; bt = f3; end
      C_LUI: begin imm = 3'd3; bs = 1'b1; end
      C_JAL: begin imm = 3'd4; bs = 1'b1; end
      default: ;
    endcase
    return {imm, bs, 4'(alu), bt};
  endfunction

  task automatic chk(input string tag, input vec_t exp);
    vec_t obs;
    obs = dut_vec();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_hold", mk(3'd0, 0, 0, 0, FLD_NONE, 0, 2'd0, 0, 2'd0, 0));
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1 chk("rst_release", mk(3'd0, 1, 0, 0, FLD_NONE, 0, 2'd0, 0, 2'd0, 0));
  endtask

  // One instruction from FETCH to retirement (or into FAULT).
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic taken, input string nm);
    cls_t        c;
    logic [10:0] fld;
    logic        st;
    c   = classify(ins[6:0]);
    fld = fields(ins);
    st  = (c == C_ST);
    for (int k = 0; k < fw; k++) begin
      @(negedge clk);
      instruction = $urandom; mem_ready = 1'b0; branch_taken = 1'($urandom);
      #1 chk({nm, ":fetch_wait"}, mk(3'd0, 1, 0, 0, FLD_NONE, 0, 2'd0, 0, 2'd0, 0));
    end
    @(negedge clk);
    instruction = ins; mem_ready = 1'b1;
    #1 chk({nm, ":fetch"}, mk(3'd0, 1, 0, 1, FLD_NONE, 0, 2'd0, 0, 2'd0, 0));
    @(negedge clk);
    instruction = $urandom; mem_ready = 1'($urandom);
    #1 chk({nm, ":decode"}, mk(3'd1, 0, 0, 0, fld, 0, 2'd0, 0, 2'd0, 0));
    if (c == C_BAD) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        mem_ready = 1'($urandom); branch_taken = 1'($urandom);
        #1 chk({nm, ":fault"}, mk(3'd5, 0, 0, 0, FLD_NONE, 0, 2'd0, 0, 2'd0, 1));
      end
      return;
    end
    @(negedge clk);
    branch_taken = taken; mem_ready = 1'($urandom);
    if (c == C_BR)
      #1 chk({nm, ":exec"}, mk(3'd2, 0, 0, 0, fld, 0, 2'd0, 1, taken ? 2'd1 : 2'd0, 0));
    else
      #1 chk({nm, ":exec"}, mk(3'd2, 0, 0, 0, fld, 0, 2'd0, 0, 2'd0, 0));
    if (c == C_BR) return;
    if (c == C_LD || c == C_ST) begin
      for (int k = 0; k < mw; k++) begin
        @(negedge clk);
        mem_ready = 1'b0;
        #1 chk({nm, ":mem_wait"}, mk(3'd3, 1, st, 0, fld, 0, 2'd0, 0, 2'd0, 0));
      end
      @(negedge clk);
      mem_ready = 1'b1;
      #1 chk({nm, ":mem_done"}, mk(3'd3, 1, st, 0, fld, 0, 2'd0, st, 2'd0, 0));
      if (st) return;
    end
    @(negedge clk);
    mem_ready = 1'($urandom);
    #1 chk({nm, ":writeback"}, mk(3'd4, 0, 0, 0, fld, 1,
                                   (c == C_LD) ? 2'd1 : ((c == C_JAL) ? 2'd2 : 2'd0),
                                   1, (c == C_JAL) ? 2'd2 : 2'd0, 0));
  endtask

  initial begin
    logic [31:0] ins;
    logic [10:0] lw_fld;
    reset = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; instruction = '0;

    do_reset();
    run_instr(32'h002081B3, 1, 0, 1'b0, "add");
    run_instr(32'h402081B3, 0, 0, 1'b0, "sub");
    run_instr(32'h4030D193, 2, 0, 1'b0, "srai");
    run_instr(32'h0080A283, 0, 3, 1'b0, "lw");
    run_instr(32'h0050A423, 1, 2, 1'b0, "sw");
    run_instr(32'h00208463, 0, 0, 1'b1, "beq_t");
    run_instr(32'h00208463, 1, 0, 1'b0, "beq_nt");
    run_instr(32'h008000EF, 0, 0, 1'b1, "jal");
    run_instr(32'h123452B7, 0, 0, 1'b0, "lui");
    run_instr(32'h0000000F, 0, 0, 1'b0, "fence");
    do_reset();

    // Reset while a load waits in MEMORY.
    lw_fld = fields(32'h0080A283);
    @(negedge clk);
    instruction = 32'h0080A283; mem_ready = 1'b1;
    #1 chk("rmem:fetch", mk(3'd0, 1, 0, 1, FLD_NONE, 0, 2'd0, 0, 2'd0, 0));
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("rmem:decode", mk(3'd1, 0, 0, 0, lw_fld, 0, 2'd0, 0, 2'd0, 0));
    @(negedge clk);
    #1 chk("rmem:exec", mk(3'd2, 0, 0, 0, lw_fld, 0, 2'd0, 0, 2'd0, 0));
    @(negedge clk);
    #1 chk("rmem:mem_wait", mk(3'd3, 1, 0, 0, lw_fld, 0, 2'd0, 0, 2'd0, 0));
    #2 reset = 1'b1;
    #1 chk("rmem:async", mk(3'd0, 0, 0, 0, FLD_NONE, 0, 2'd0, 0, 2'd0, 0));
    mem_ready = 1'b1;
    @(negedge clk);
    #1 chk("rmem:held", mk(3'd0, 0, 0, 0, FLD_NONE, 0, 2'd0, 0, 2'd0, 0));
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1 chk("rmem:release", mk(3'd0, 1, 0, 0, FLD_NONE, 0, 2'd0, 0, 2'd0, 0));
    run_instr(32'h002081B3, 2, 0, 1'b0, "add_after_rst");

    for (int n = 0; n < 60; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 9))
        0, 7: ins[6:0] = 7'h33;
        1, 8: ins[6:0] = 7'h13;
        2:    ins[6:0] = 7'h03;
        3:    ins[6:0] = 7'h23;
        4:    ins[6:0] = 7'h63;
        5:    ins[6:0] = 7'h37;
        6:    ins[6:0] = 7'h6F;
        default: ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'h73 : 7'h17;
      endcase
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), "rand");
      if (classify(ins[6:0]) == C_BAD) do_reset();
    end

    do_reset();
    mem_ready = 1'b0;
`ifdef CTRL_TIMEOUT_EN
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      #1 chk("tmo:wait", mk(3'd0, 1, 0, 0, FLD_NONE, 0, 2'd0, 0, 2'd0, 0));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("tmo:fault", mk(3'd5, 0, 0, 0, FLD_NONE, 0, 2'd0, 0, 2'd0, 1));
    end
`else
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      #1 chk("notmo:wait", mk(3'd0, 1, 0, 0, FLD_NONE, 0, 2'd0, 0, 2'd0, 0));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
